temp_sample_sequencer: RTL

//  Periodic sampling controller in front of the TemperatureCalculator datapath.
//  - Runs an ADC request/acknowledge handshake on a fixed sample period.
//  - Latches calibration (tc_base, tc_ref) once per sample and drives the calculator inputs.
//  - Waits the calculator latency, then presents tempc on a valid/ready output with sticky error flags.

---
 rtl/temp_sample_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/temp_sample_sequencer.sv
// Periodic sampler for the temperature calculator: issues ADC requests on a fixed period,
// latches calibration per sample, waits out the calculator latency and hands tempc to a valid/ready consumer.
module temp_sample_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int CALC_LATENCY  = 2,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr_err,
    input  logic [31:0] tc_base_cfg,
    input  logic [7:0]  tc_ref_cfg,
    output logic        adc_req,
    input  logic        adc_ack,
    input  logic [15:0] adc_dout,
    output logic [31:0] calc_base,
    output logic [7:0]  calc_ref,
    output logic [15:0] calc_adc,
    input  logic [31:0] calc_tempc,
    output logic [31:0] temp_out,
    output logic        temp_valid,
    input  logic        temp_ready,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int LW = $clog2(CALC_LATENCY + 1);
    localparam logic [PW-1:0] PERIOD_MAX  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(ACK_TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_MAX     = LW'(CALC_LATENCY);

    // Handshakes: adc_req stays high until adc_ack is sampled high (or the wait expires);
    // a result transfers on any rising edge where temp_valid & temp_ready are both high.
    typedef enum logic [1:0] {IDLE, REQ, CALC} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] wait_cnt;
    logic [LW-1:0] lat_cnt;
    logic          tick, start, ack_take, ack_expire, capture;
    logic          overrun_set;

    assign tick    = enable && (period_cnt == PERIOD_MAX);
    assign adc_req = (state == REQ);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        ack_take   = 1'b0;
        ack_expire = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // An ack on the final allowed cycle still counts as a good sample.
                if (adc_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = CALC;
                end else if (wait_cnt == TIMEOUT_MAX) begin
                    ack_expire = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            CALC: begin
                if (lat_cnt == LAT_MAX) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign overrun_set = (capture && temp_valid && !temp_ready) || (tick && busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (!enable || period_cnt == PERIOD_MAX) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Both phase counters restart whenever their state is left, so each visit begins at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            wait_cnt <= (state == REQ)  ? wait_cnt + 1'b1 : '0;
            lat_cnt  <= (state == CALC) ? lat_cnt + 1'b1  : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calc_base <= '0;
            calc_ref  <= '0;
            calc_adc  <= '0;
        end else begin
            if (start) begin
                calc_base <= tc_base_cfg;
                calc_ref  <= tc_ref_cfg;
            end
            if (ack_take) begin
                calc_adc <= adc_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_out   <= '0;
            temp_valid <= 1'b0;
        end else if (capture) begin
            temp_out   <= calc_tempc;
            temp_valid <= 1'b1;
        end else if (temp_valid && temp_ready) begin
            temp_valid <= 1'b0;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (ack_expire) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
